// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the ID/EX register, the EX-stage mul/div unit and EX/MEM.
// The master drives the decoded instruction; the slave is the mul/div unit.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_start;
    logic [2:0]       in_md_op;
    logic [WIDTH-1:0] in_data_register_rs1;
    logic [WIDTH-1:0] in_data_register_rs2;
    logic [4:0]       in_reg_rd;
    logic             in_write_register;
    logic             in_flush;

    logic             out_stall_hold;
    logic             out_busy;
    logic             out_done;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_reg_rd;
    logic             out_write_register;

    modport master (
        output in_start, in_md_op, in_data_register_rs1, in_data_register_rs2,
               in_reg_rd, in_write_register, in_flush,
        input  out_stall_hold, out_busy, out_done, out_result, out_reg_rd,
               out_write_register
    );

    modport slave (
        input  in_start, in_md_op, in_data_register_rs1, in_data_register_rs2,
               in_reg_rd, in_write_register, in_flush,
        output out_stall_hold, out_busy, out_done, out_result, out_reg_rd,
               out_write_register
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide: shift-add multiply and restoring divide, one bit
// per cycle, with single-cycle fast paths for divide-by-zero, signed overflow and reserved ops.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    ex_muldiv_if.slave  md
);
    localparam int                CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  SIGN_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_REM   = 3'b100;
    localparam logic [2:0] OP_REMU  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2:0]         op_q, op_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         rd_q, rd_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Decode of the instruction presented by ID/EX
    logic             in_is_mul, in_is_rsvd, in_is_div, in_is_quot, in_is_signed;
    logic             a_neg, b_neg, div_zero, signed_ovf, fast_path;
    logic [WIDTH-1:0] a_abs, b_abs, fast_result;

    assign in_is_mul    = (md.in_md_op == OP_MUL) || (md.in_md_op == OP_MULHU);
    assign in_is_rsvd   = md.in_md_op[2] & md.in_md_op[1];
    assign in_is_div    = !in_is_mul && !in_is_rsvd;
    assign in_is_quot   = (md.in_md_op == OP_DIV) || (md.in_md_op == OP_DIVU);
    assign in_is_signed = (md.in_md_op == OP_DIV) || (md.in_md_op == OP_REM);

    assign a_neg = in_is_signed & md.in_data_register_rs1[WIDTH-1];
    assign b_neg = in_is_signed & md.in_data_register_rs2[WIDTH-1];
    assign a_abs = a_neg ? -md.in_data_register_rs1 : md.in_data_register_rs1;
    assign b_abs = b_neg ? -md.in_data_register_rs2 : md.in_data_register_rs2;

    assign div_zero   = in_is_div && (md.in_data_register_rs2 == '0);
    assign signed_ovf = in_is_signed && (md.in_data_register_rs1 == SIGN_MIN)
                        && (md.in_data_register_rs2 == '1);
    assign fast_path  = in_is_rsvd || div_zero || signed_ovf;

    // NOTE: every signal written in an always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            fast_result = in_is_quot ? '1 : md.in_data_register_rs1;
        end else if (signed_ovf) begin
            fast_result = in_is_quot ? SIGN_MIN : '0;
        end
    end

    // One iteration of each algorithm; acc holds {hi, lo} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic [WIDTH:0]     mul_hi;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   step_quot, step_rem, final_result;
    logic               op_is_mul;
    logic               unused_div_bit;

    assign op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);

    assign mul_hi   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_step = {mul_hi, acc_q[WIDTH-1:1]};

    // The remainder stays below the divisor, so a failed trial subtraction never
    // needs the top bit of the shifted remainder.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    assign div_step  = div_diff[WIDTH+1]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    assign unused_div_bit = div_diff[WIDTH];

    assign step_acc  = op_is_mul ? mul_step : div_step;
    assign step_quot = step_acc[WIDTH-1:0];
    assign step_rem  = step_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        final_result = '0;
        case (op_q)
            OP_MUL:   final_result = step_acc[WIDTH-1:0];
            OP_MULHU: final_result = step_acc[2*WIDTH-1:WIDTH];
            OP_DIV:   final_result = q_neg_q ? -step_quot : step_quot;
            OP_DIVU:  final_result = step_quot;
            OP_REM:   final_result = r_neg_q ? -step_rem : step_rem;
            OP_REMU:  final_result = step_rem;
            default:  final_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        rd_d     = rd_q;
        we_d     = we_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (md.in_start && !md.in_flush) begin
                    op_d  = md.in_md_op;
                    rd_d  = md.in_reg_rd;
                    we_d  = md.in_write_register;
                    cnt_d = '0;
                    if (fast_path) begin
                        result_d = fast_result;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, (in_is_mul ? md.in_data_register_rs2 : a_abs)};
                        opb_d   = in_is_mul ? md.in_data_register_rs1 : b_abs;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        state_d = ST_BUSY;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_BUSY: begin
                if (md.in_flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    if (cnt_q == LAST_ITER) begin
                        result_d = final_result;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        busy_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Stall drops in DONE so the completing instruction advances into EX/MEM.
    assign md.out_stall_hold     = ((state_q == ST_IDLE) && md.in_start && !md.in_flush)
                                 || (state_q == ST_BUSY);
    assign md.out_busy           = busy_q;
    assign md.out_done           = done_q;
    assign md.out_result         = result_q;
    assign md.out_reg_rd         = rd_q;
    assign md.out_write_register = done_q & we_q & ~md.in_flush;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them whenever out_done is seen.
module tb_ex_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    int   done_cycs[$];
    logic [31:0] last_exp = '0;

    ex_muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_done === 1'b1) begin
                done_cycs.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: out_done=1 with no outstanding op (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_result"}, bus.out_result, e.result);
                    check({e.name, "_rd"}, 32'(bus.out_reg_rd), 32'(e.rd));
                    check({e.name, "_wr"}, 32'(bus.out_write_register), 32'(e.we));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we);
        bus.in_md_op             = op;
        bus.in_data_register_rs1 = a;
        bus.in_data_register_rs2 = b;
        bus.in_reg_rd            = rd;
        bus.in_write_register    = we;
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input logic we,
                            input string name);
        exp_t e;
        e.result = res;
        e.rd     = rd;
        e.we     = we;
        e.name   = name;
        sb_q.push_back(e);
        last_exp = res;
    endtask

    // Issue one op from IDLE; exp_lat is cycles from accept edge to the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic we, input logic [31:0] exp,
                          input string name, input int exp_lat, input bit flush_done);
        int lat;
        int stalls;
        int busys;
        @(posedge clk);
        #1;
        drive(op, a, b, rd, we);
        bus.in_start = 1'b1;
        push_exp(exp, rd, we & ~flush_done, name);
        @(negedge clk);
        stalls = int'(bus.out_stall_hold);
        busys  = 0;
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        if (flush_done) bus.in_flush = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            stalls += int'(bus.out_stall_hold);
            busys  += int'(bus.out_busy);
            if (bus.out_done === 1'b1) break;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busys), 32'(exp_lat - 1));
        @(posedge clk);
        #1;
        bus.in_flush = 1'b0;
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(bus.out_done), 32'd0);
    endtask

    initial begin
        int lat;
        bus.in_start = 1'b0;
        bus.in_flush = 1'b0;
        drive(3'b000, '0, '0, '0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.out_busy), 32'd0);
        check("rst_done", 32'(bus.out_done), 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_rd", 32'(bus.out_reg_rd), 32'd0);
        check("rst_wr", 32'(bus.out_write_register), 32'd0);
        check("rst_stall", 32'(bus.out_stall_hold), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Long-path multiply / divide
        run_op(3'b000, 32'd7,        32'd6,        5'd5,  1'b1, 32'd42,       "mul_7x6",     33, 1'b0);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  1'b1, 32'hFFFFFFFE, "mulhu_max",   33, 1'b0);
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b0, 32'h00000001, "mul_max",     33, 1'b0);
        run_op(3'b001, 32'h80000000, 32'd4,        5'd8,  1'b1, 32'd2,        "mulhu_2p33",  33, 1'b0);
        run_op(3'b010, 32'hFFFFFFF9, 32'd2,        5'd9,  1'b1, 32'hFFFFFFFD, "div_m7_2",    33, 1'b0);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 1'b1, 32'hFFFFFFFF, "rem_m7_2",    33, 1'b0);
        run_op(3'b010, 32'd7,        32'hFFFFFFFE, 5'd11, 1'b1, 32'hFFFFFFFD, "div_7_m2",    33, 1'b0);
        run_op(3'b100, 32'd7,        32'hFFFFFFFE, 5'd12, 1'b1, 32'd1,        "rem_7_m2",    33, 1'b0);
        run_op(3'b010, 32'hFFFFFFF8, 32'hFFFFFFFF, 5'd13, 1'b1, 32'd8,        "div_m8_m1",   33, 1'b0);
        run_op(3'b011, 32'd100,      32'd7,        5'd14, 1'b1, 32'd14,       "divu_100_7",  33, 1'b0);
        run_op(3'b101, 32'd100,      32'd7,        5'd15, 1'b0, 32'd2,        "remu_100_7",  33, 1'b0);
        run_op(3'b011, 32'hFFFFFFFF, 32'd1,        5'd16, 1'b1, 32'hFFFFFFFF, "divu_max_1",  33, 1'b0);

        // Fast paths
        run_op(3'b011, 32'd5,        32'd0,        5'd17, 1'b1, 32'hFFFFFFFF, "divu_5_0",    1, 1'b0);
        run_op(3'b100, 32'd5,        32'd0,        5'd18, 1'b1, 32'd5,        "rem_5_0",     1, 1'b0);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd19, 1'b1, 32'h80000000, "div_ovf",     1, 1'b0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd20, 1'b1, 32'd0,        "rem_ovf",     1, 1'b0);
        run_op(3'b110, 32'd9,        32'd3,        5'd21, 1'b1, 32'd0,        "reserved",    1, 1'b0);
        run_op(3'b101, 32'd5,        32'd0,        5'd22, 1'b1, 32'd5,        "remu_flushdone", 1, 1'b1);

        // Flush in IDLE blocks acceptance
        @(posedge clk);
        #1;
        drive(3'b011, 32'd100, 32'd7, 5'd23, 1'b1);
        bus.in_start = 1'b1;
        bus.in_flush = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_flush_stall", 32'(bus.out_stall_hold), 32'd0);
        check("idle_flush_busy", 32'(bus.out_busy), 32'd0);
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        bus.in_flush = 1'b0;
        repeat (40) @(posedge clk);

        // Flush 10 cycles into a DIVU
        @(posedge clk);
        #1;
        drive(3'b011, 32'd100, 32'd7, 5'd24, 1'b1);
        bus.in_start = 1'b1;
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.in_flush = 1'b1;
        @(negedge clk);
        check("flush_busy_before", 32'(bus.out_busy), 32'd1);
        @(posedge clk);
        #1;
        bus.in_flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(bus.out_busy), 32'd0);
        check("flush_stall", 32'(bus.out_stall_hold), 32'd0);
        check("flush_done", 32'(bus.out_done), 32'd0);
        check("flush_result_held", bus.out_result, last_exp);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_still_idle", 32'(bus.out_busy), 32'd0);

        // Reset 10 cycles into a DIVU
        @(posedge clk);
        #1;
        drive(3'b011, 32'd100, 32'd7, 5'd25, 1'b1);
        bus.in_start = 1'b1;
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.out_busy), 32'd0);
        check("midrst_done", 32'(bus.out_done), 32'd0);
        check("midrst_result", bus.out_result, 32'd0);
        check("midrst_rd", 32'(bus.out_reg_rd), 32'd0);
        check("midrst_wr", 32'(bus.out_write_register), 32'd0);
        check("midrst_stall", 32'(bus.out_stall_hold), 32'd0);
        repeat (40) @(posedge clk);

        // Back-to-back MULs with in_start held through DONE
        @(posedge clk);
        #1;
        drive(3'b000, 32'd3, 32'd4, 5'd26, 1'b1);
        bus.in_start = 1'b1;
        push_exp(32'd12, 5'd26, 1'b1, "b2b_first");
        @(posedge clk);
        #1;
        drive(3'b000, 32'd5, 32'd5, 5'd27, 1'b1);
        push_exp(32'd25, 5'd27, 1'b1, "b2b_second");
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_done === 1'b1) break;
        end
        check("b2b_first_latency", 32'(lat), 32'd33);
        check("b2b_done_stall", 32'(bus.out_stall_hold), 32'd0);
        @(negedge clk);
        check("b2b_idle_stall", 32'(bus.out_stall_hold), 32'd1);
        check("b2b_idle_busy", 32'(bus.out_busy), 32'd0);
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_done === 1'b1) break;
        end
        check("b2b_second_latency", 32'(lat), 32'd33);
        @(negedge clk);
        if (done_cycs.size() >= 2) begin
            check("b2b_done_spacing",
                  32'(done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2]), 32'd34);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL b2b_done_spacing: only %0d done pulses seen", done_cycs.size());
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
